// File: rtl/tl_uart_pkg.sv
// Shared definitions for the TileLink <-> UART byte-stream bridges.
// The opcode-byte layout is common to both directions of the link.
package tl_uart_pkg;

    localparam int PKT_HDR_BYTES = 4;

    localparam logic [2:0] CHAN_A = 3'd0;
    localparam logic [2:0] CHAN_B = 3'd1;
    localparam logic [2:0] CHAN_C = 3'd2;
    localparam logic [2:0] CHAN_D = 3'd3;
    localparam logic [2:0] CHAN_E = 3'd4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } ser_state_e;

    function automatic logic [7:0] pack_op_byte(input logic       corrupt,
                                                input logic [2:0] param,
                                                input logic [2:0] opcode);
        return {corrupt, param, 1'b0, opcode};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pointers carry an extra MSB so full and empty are
// distinguishable without a separate count register.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr, rptr;
    logic             do_push, do_pop;

    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty   = (wptr == rptr);
    assign level   = wptr - rptr;
    assign rdata   = mem[rptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage is not reset; a flushed FIFO is empty so stale words are never read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/tilelink_to_uart_serializer.sv
// Filters TileLink frames by channel, packs them into little-endian packets,
// queues them and streams each packet byte-by-byte to the UART transmitter.
module tilelink_to_uart_serializer
    import tl_uart_pkg::*;
#(
    parameter int ADDR_BYTES   = 4,
    parameter int DATA_BYTES   = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int DROP_ON_FULL = 0,
    parameter int CNT_W        = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  chan_enable,
    input  logic                        tl_in_valid,
    output logic                        tl_in_ready,
    input  logic [2:0]                  tl_in_bits_chanId,
    input  logic [2:0]                  tl_in_bits_opcode,
    input  logic [2:0]                  tl_in_bits_param,
    input  logic [7:0]                  tl_in_bits_size,
    input  logic [7:0]                  tl_in_bits_source,
    input  logic [63:0]                 tl_in_bits_address,
    input  logic [63:0]                 tl_in_bits_data,
    input  logic                        tl_in_bits_corrupt,
    input  logic [8:0]                  tl_in_bits_union,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    output logic [7:0]                  tx_data,
    output logic                        tx_last,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [CNT_W-1:0]            drop_count
);
    localparam int PKT_BYTES = PKT_HDR_BYTES + ADDR_BYTES + DATA_BYTES;
    localparam int PKT_W     = 8 * PKT_BYTES;
    localparam int IDX_W     = $clog2(PKT_BYTES);
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1;

    logic [PKT_BYTES-1:0][7:0] pkt_in, pkt_head;
    logic [PKT_W-1:0]          fifo_wdata, fifo_rdata;
    logic                      fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic                      chan_en, accept, frame_drop, fifo_more;

    ser_state_e                state, state_nxt;
    logic [IDX_W-1:0]          byte_idx, byte_idx_nxt;
    logic                      is_last;

    // Source id and the unused upper address/data/union bits are not transmitted.
    logic unused_bits;
    assign unused_bits = ^{tl_in_bits_source, tl_in_bits_union[8],
                           tl_in_bits_address, tl_in_bits_data};

    // Byte 0 sits in the least significant position of the packed word.
    assign pkt_in = {tl_in_bits_data[8*DATA_BYTES-1:0],
                     tl_in_bits_address[8*ADDR_BYTES-1:0],
                     tl_in_bits_union[7:0],
                     tl_in_bits_size,
                     pack_op_byte(tl_in_bits_corrupt, tl_in_bits_param, tl_in_bits_opcode),
                     {5'b0, tl_in_bits_chanId}};

    assign chan_en     = chan_enable[tl_in_bits_chanId];
    assign tl_in_ready = (DROP_ON_FULL != 0) ? 1'b1 : (!fifo_full || !chan_en);
    assign accept      = tl_in_valid && tl_in_ready;
    assign fifo_push   = accept && chan_en && !fifo_full;
    assign frame_drop  = accept && chan_en && fifo_full;

    assign fifo_wdata  = pkt_in;
    assign pkt_head    = fifo_rdata;

    sync_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (reset)
            drop_count <= '0;
        else if (frame_drop && (drop_count != '1))
            drop_count <= drop_count + 1'b1;
    end

    // A packet stays in the FIFO until its last byte leaves, so after the pop
    // another one is ready if more than one was queued or one arrives now.
    assign is_last   = (byte_idx == IDX_W'(PKT_BYTES - 1));
    assign fifo_more = (fifo_level > LVL_W'(1)) || fifo_push;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            byte_idx <= '0;
        end else begin
            state    <= state_nxt;
            byte_idx <= byte_idx_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        byte_idx_nxt = byte_idx;
        tx_valid     = 1'b0;
        tx_data      = '0;
        tx_last      = 1'b0;
        fifo_pop     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_nxt    = S_SEND;
                    byte_idx_nxt = '0;
                end
            end
            S_SEND: begin
                tx_valid = 1'b1;
                tx_data  = pkt_head[byte_idx];
                tx_last  = is_last;
                if (tx_ready) begin
                    if (is_last) begin
                        fifo_pop     = 1'b1;
                        byte_idx_nxt = '0;
                        if (!fifo_more) state_nxt = S_IDLE;
                    end else begin
                        byte_idx_nxt = byte_idx + 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: doc/tilelink_to_uart_serializer.md
Name: tilelink_to_uart_serializer

Overview:
Single-clock successor to the TileLink-to-UART response path. Accepts deserialized TileLink frames and filters them by channel. Buffers accepted frames in a parametrised FIFO, packs each into a little-endian packet of configurable length, and streams it byte-by-byte to the UART TX byte interface. Sits after the clock-crossing stage, directly in front of the UART transmitter; no CDC inside.

Parameters:
ADDR_BYTES, 4, address bytes in packet (4 or 8); taken from tl_in_bits_address LSBs.
DATA_BYTES, 8, data bytes in packet (1..8); taken from tl_in_bits_data LSBs.
FIFO_DEPTH, 4, packet FIFO entries (power of 2, >=2).
DROP_ON_FULL, 0, 0 = backpressure when full; 1 = accept and discard when full, count drop.
CNT_W, 16, width of drop counter.

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
chan_enable  in  8  per-chanId accept mask; a frame whose bit is clear is consumed and discarded
tl_in_valid  in  1  frame valid
tl_in_ready  out  1  frame ready
tl_in_bits_chanId  in  3  channel
tl_in_bits_opcode  in  3  opcode
tl_in_bits_param  in  3  param
tl_in_bits_size  in  8  log2 size
tl_in_bits_source  in  8  source (not transmitted)
tl_in_bits_address  in  64  address
tl_in_bits_data  in  64  data
tl_in_bits_corrupt  in  1  corrupt
tl_in_bits_union  in  9  denied/mask
tx_valid  out  1  byte valid
tx_ready  in  1  UART TX ready
tx_data  out  8  byte
tx_last  out  1  high on the final byte of a packet
fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries
drop_count  out  CNT_W  saturating count of frames dropped on full

Behaviour:
- Clock is clk. Reset is synchronous, active-high.
- Packet length is PKT_BYTES = 4 + ADDR_BYTES + DATA_BYTES.
- Packet byte layout:
  - byte0 = {5'b0, chanId}
  - byte1 = {corrupt, param, 1'b0, opcode}
  - byte2 = size
  - byte3 = union[7:0]
  - then address, LSB first, ADDR_BYTES bytes
  - then data, LSB first, DATA_BYTES bytes
- Packing is combinational at FIFO input; FIFO stores 8*PKT_BYTES bits.
- Input handshake: transfer when tl_in_valid && tl_in_ready.
  - DROP_ON_FULL=0: tl_in_ready = !full || (chan_enable[chanId]==0). Filtered frames are always accepted.
  - DROP_ON_FULL=1: tl_in_ready = 1.
  - tl_in_ready never depends on tx_ready. A full FIFO stays not-ready even if a pop occurs that cycle.
- On an accepted frame:
  - If the channel is enabled and the FIFO is not full, push.
  - If the channel is enabled and the FIFO is full (only possible with DROP_ON_FULL=1), drop and increment drop_count. drop_count saturates at all-ones.
  - If the channel is disabled, discard with no count.
- Serializer FSM:
  - IDLE: if FIFO not empty, move to SEND and load byte_idx=0.
  - SEND: tx_valid=1, tx_data=head byte[byte_idx], tx_last=(byte_idx==PKT_BYTES-1).
  - On tx_ready, increment byte_idx. On the last byte with tx_ready, pop the FIFO. If the FIFO is still non-empty after the pop, stay in SEND with byte_idx=0 (back-to-back packets, no bubble); otherwise go to IDLE.
- Latency: a frame pushed in cycle N into an empty FIFO gives tx_valid=1 in cycle N+2 (N+1 FIFO write, N+2 FSM in SEND).
- tx_data/tx_last are stable while tx_valid && !tx_ready. tx_valid never drops mid-packet.
- Simultaneous push and pop in the same cycle are both honoured; fifo_level is unchanged.
- Reset values: tl_in_ready reflects the empty FIFO (1). tx_valid=0, tx_last=0, tx_data=0, fifo_level=0, drop_count=0, FSM=IDLE, byte_idx=0.
- Reset mid-packet: the packet is abandoned, the FIFO is flushed, and tx_valid=0 in the cycle after reset is sampled.
- Pointer wrap-around uses an extra pointer MSB for full/empty.

Decomposition:
- Shared package tl_uart_pkg: PKT_HDR_BYTES=4, CHAN_A..CHAN_E ids, and the opcode-byte packing function (shared with the uart-to-tilelink direction).
- One sub-module: sync_fifo (WIDTH, DEPTH; push/pop/full/empty/level). The serializer FSM stays in the top.

Test Plan:
- Default params, chan_enable=8'h08: one Ch D frame (opcode=1, param=0, size=3, union=0, addr=0x80001000, data=0x1122334455667788) -> 16 bytes 03 01 03 00 00 10 00 80 88 77 66 55 44 33 22 11; tx_last only on byte 15; first tx_valid 2 cycles after accept.
- chan_enable=8'h08, frame with chanId=1 -> tl_in_ready=1, no TX bytes, fifo_level stays 0, drop_count stays 0.
- DROP_ON_FULL=0, tx_ready=0, push 5 frames -> fifo_level=4, tl_in_ready=0 on the 5th; raise tx_ready -> 5 packets sent in order, 80 bytes with no inter-packet bubbles.
- DROP_ON_FULL=1, tx_ready=0, push 7 frames -> fifo_level=4, drop_count=3; the 4 oldest are sent. With CNT_W=2, push 10 extra frames -> drop_count holds at 3.
- ADDR_BYTES=8, DATA_BYTES=4: addr=0x0123456789ABCDEF, data=0xDEADBEEF -> 16 bytes, address bytes EF CD AB 89 67 45 23 01, data bytes EF BE AD DE.
- Assert reset at byte 6 of a packet with 2 more queued -> tx_valid=0 the next cycle, fifo_level=0, no residual bytes after reset release.
